// File: rtl/raymarch_result_collector.sv
// Raymarch result collector: buffers one finished pixel per lane, picks one
// lane per cycle round-robin, and turns it into a frame-buffer write. It also
// tracks frame completion and keeps sticky drop / out-of-range flags.
module raymarch_result_collector #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720,
  parameter int unsigned LANES  = 3,
  parameter int unsigned XW     = $clog2(WIDTH),
  parameter int unsigned YW     = $clog2(HEIGHT),
  parameter int unsigned AW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [LANES-1:0]      px_valid_in,
  input  logic [LANES*XW-1:0]   px_x_in,
  input  logic [LANES*YW-1:0]   px_y_in,
  input  logic [LANES*24-1:0]   px_color_in,
  output logic [LANES-1:0]      lane_ready_out,
  output logic                  wr_en_out,
  output logic [AW-1:0]         wr_addr_out,
  output logic [23:0]           wr_data_out,
  output logic                  frame_done_out,
  output logic [AW:0]           pixels_written_out,
  output logic                  overflow_out,
  output logic                  range_err_out
);

  localparam int unsigned PW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;
  localparam int unsigned CW  = AW + 1;
  localparam logic [XW:0]   X_LIM  = XW1'(WIDTH);
  localparam logic [YW:0]   Y_LIM  = YW1'(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(LANES - 1);

  logic [LANES-1:0] hold_valid;
  logic [XW-1:0]    hold_x [LANES];
  logic [YW-1:0]    hold_y [LANES];
  logic [23:0]      hold_c [LANES];
  logic [PW-1:0]    rr_ptr;

  logic             grant;
  logic [PW-1:0]    gidx;
  logic [XW-1:0]    gx;
  logic [YW-1:0]    gy;
  logic [23:0]      gc;
  logic [PW-1:0]    rr_next;
  logic             in_range;
  logic             last_px;
  logic             wr_now;
  logic [AW-1:0]    addr_calc;
  logic [LANES-1:0] load;
  logic             drop;

  assign lane_ready_out = ~hold_valid;

  // Round-robin pick: first pending lane at or above rr_ptr, else wrap to the lowest
  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    gx    = '0;
    gy    = '0;
    gc    = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (!grant && hold_valid[l] && (PW'(l) >= rr_ptr)) begin
        grant = 1'b1;
        gidx  = PW'(l);
        gx    = hold_x[l];
        gy    = hold_y[l];
        gc    = hold_c[l];
      end
    end
    for (int l = 0; l < int'(LANES); l++) begin
      if (!grant && hold_valid[l] && (PW'(l) < rr_ptr)) begin
        grant = 1'b1;
        gidx  = PW'(l);
        gx    = hold_x[l];
        gy    = hold_y[l];
        gc    = hold_c[l];
      end
    end
  end

  // Granted-result decode: range check, last-pixel detect, linear address
  always_comb begin
    rr_next   = (gidx == P_LAST) ? '0 : gidx + 1'b1;
    in_range  = ({1'b0, gx} < X_LIM) && ({1'b0, gy} < Y_LIM);
    last_px   = (gx == X_LAST) && (gy == Y_LAST);
    wr_now    = grant && in_range;
    addr_calc = AW'(gx) + AW'(WIDTH) * AW'(gy);
  end

  // A lane accepts a new result when empty or when it is being drained this edge
  always_comb begin
    load = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      load[i] = px_valid_in[i] && (!hold_valid[i] || (grant && (gidx == PW'(i))));
    end
    drop = |(px_valid_in & ~load);
  end

  // Per-lane hold registers and round-robin pointer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < int'(LANES); i++) begin
        hold_x[i] <= '0;
        hold_y[i] <= '0;
        hold_c[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (load[i]) begin
          hold_valid[i] <= 1'b1;
          hold_x[i]     <= px_x_in[i*XW +: XW];
          hold_y[i]     <= px_y_in[i*YW +: YW];
          hold_c[i]     <= px_color_in[i*24 +: 24];
        end else if (grant && (gidx == PW'(i))) begin
          hold_valid[i] <= 1'b0;
        end
      end
      if (grant) begin
        rr_ptr <= rr_next;
      end
    end
  end

  // Write port, frame tracking and sticky error flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_en_out          <= 1'b0;
      wr_addr_out        <= '0;
      wr_data_out        <= '0;
      frame_done_out     <= 1'b0;
      pixels_written_out <= '0;
      overflow_out       <= 1'b0;
      range_err_out      <= 1'b0;
    end else begin
      wr_en_out      <= wr_now;
      frame_done_out <= wr_now && last_px;
      if (wr_now) begin
        wr_addr_out <= addr_calc;
        wr_data_out <= gc;
      end
      // The closing pixel of a frame is not counted; the count restarts after it
      if (frame_done_out) begin
        pixels_written_out <= (wr_now && !last_px) ? CW'(1) : '0;
      end else if (wr_now && !last_px) begin
        pixels_written_out <= pixels_written_out + CW'(1);
      end
      overflow_out  <= overflow_out | drop;
      range_err_out <= range_err_out | (grant && !in_range);
    end
  end

endmodule

// File: tb/tb_raymarch_result_collector.sv
// Bench for raymarch_result_collector: scoreboard of expected writes filled
// by the stimulus and drained by a write-port monitor.
module tb_raymarch_result_collector;

  localparam int unsigned WIDTH  = 1280;
  localparam int unsigned HEIGHT = 720;
  localparam int unsigned LANES  = 3;
  localparam int unsigned XW     = 11;
  localparam int unsigned YW     = 10;
  localparam int unsigned AW     = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic [LANES-1:0]    px_valid;
  logic [LANES*XW-1:0] px_x;
  logic [LANES*YW-1:0] px_y;
  logic [LANES*24-1:0] px_color;
  logic [LANES-1:0]    lane_ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [23:0]         wr_data;
  logic                frame_done;
  logic [AW:0]         pixels_written;
  logic                overflow;
  logic                range_err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    logic          fd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_wr = 0;
  int   n_fd = 0;
  int   w0;
  bit   seen;

  raymarch_result_collector #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LANES(LANES),
    .XW(XW), .YW(YW), .AW(AW)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .px_valid_in        (px_valid),
    .px_x_in            (px_x),
    .px_y_in            (px_y),
    .px_color_in        (px_color),
    .lane_ready_out     (lane_ready),
    .wr_en_out          (wr_en),
    .wr_addr_out        (wr_addr),
    .wr_data_out        (wr_data),
    .frame_done_out     (frame_done),
    .pixels_written_out (pixels_written),
    .overflow_out       (overflow),
    .range_err_out      (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic put(input int lane, input int x, input int y, input logic [23:0] c);
    px_valid = px_valid | (LANES'(1) << lane);
    px_x[lane*XW +: XW]     = XW'(x);
    px_y[lane*YW +: YW]     = YW'(y);
    px_color[lane*24 +: 24] = c;
  endtask

  task automatic expect_wr(input int x, input int y, input logic [23:0] c, input logic fd);
    exp_t e;
    e.addr = AW'(x + int'(WIDTH) * y);
    e.data = c;
    e.fd   = fd;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    px_valid = '0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    px_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Write-port monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        n_wr++;
        if (frame_done) n_fd++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
          chk("wr_data", 64'(wr_data), 64'(mon_e.data));
          chk("wr_frame_done", 64'(frame_done), 64'(mon_e.fd));
        end
      end else begin
        chk("frame_done_idle", 64'(frame_done), 64'(0));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    px_valid = '0;
    px_x     = '0;
    px_y     = '0;
    px_color = '0;
    do_reset();

    // Reset state
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_lane_ready", 64'(lane_ready), 64'(3'b111));
    chk("rst_pixels", 64'(pixels_written), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_range_err", 64'(range_err), 64'(0));

    // Single result on lane 0, latency two cycles
    put(0, 5, 2, 24'hFF0000);
    expect_wr(5, 2, 24'hFF0000, 1'b0);
    step();
    chk("lat_n1_wr_en", 64'(wr_en), 64'(0));
    chk("lat_n1_ready", 64'(lane_ready), 64'(3'b110));
    step();
    chk("lat_n2_wr_en", 64'(wr_en), 64'(1));
    chk("lat_n2_addr", 64'(wr_addr), 64'(2565));
    chk("lat_n2_pixels", 64'(pixels_written), 64'(1));
    step();
    chk("lat_ready_back", 64'(lane_ready), 64'(3'b111));

    // All lanes at once from rr_ptr=0: written in order 0,1,2
    do_reset();
    put(0, 10, 0, 24'h000A01);
    put(1, 20, 1, 24'h000B02);
    put(2, 30, 2, 24'h000C03);
    expect_wr(10, 0, 24'h000A01, 1'b0);
    expect_wr(20, 1, 24'h000B02, 1'b0);
    expect_wr(30, 2, 24'h000C03, 1'b0);
    repeat (6) step();
    chk("all_overflow", 64'(overflow), 64'(0));
    chk("all_pixels", 64'(pixels_written), 64'(3));
    chk("all_sb_empty", 64'(sb.size()), 64'(0));

    // Lane 1 pulses twice while lane 0 wins: second lane-1 result dropped
    put(0, 40, 3, 24'h123456);
    put(1, 41, 3, 24'h654321);
    expect_wr(40, 3, 24'h123456, 1'b0);
    expect_wr(41, 3, 24'h654321, 1'b0);
    step();
    put(1, 42, 3, 24'hABCDEF);
    step();
    chk("ovf_set", 64'(overflow), 64'(1));
    repeat (4) step();
    chk("ovf_sticky", 64'(overflow), 64'(1));
    chk("ovf_pixels", 64'(pixels_written), 64'(5));
    chk("ovf_sb_empty", 64'(sb.size()), 64'(0));

    // Out-of-range x on lane 2: consumed without a write
    put(2, int'(WIDTH), 0, 24'h00FF00);
    step();
    chk("rng_n1_ready", 64'(lane_ready), 64'(3'b011));
    step();
    chk("rng_n2_ready", 64'(lane_ready), 64'(3'b111));
    chk("rng_err", 64'(range_err), 64'(1));
    chk("rng_no_wr", 64'(wr_en), 64'(0));
    repeat (2) step();
    chk("rng_pixels", 64'(pixels_written), 64'(5));

    // Tail of a frame streamed through lane 0 at full rate
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i >= 1) chk("refill_ready0", 64'(lane_ready[0]), 64'(0));
      put(0, int'(WIDTH) - 5 + i, int'(HEIGHT) - 1, 24'h010000 + 24'(i));
      expect_wr(int'(WIDTH) - 5 + i, int'(HEIGHT) - 1, 24'h010000 + 24'(i), (i == 4));
      step();
    end
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (frame_done) seen = 1'b1;
      else step();
    end
    chk("frame_done_seen", 64'(seen), 64'(1));
    if (seen) begin
      chk("frame_last_addr", 64'(wr_addr), 64'(921599));
      chk("frame_pixels_at_done", 64'(pixels_written), 64'(4));
      step();
      chk("frame_pixels_after", 64'(pixels_written), 64'(0));
      chk("frame_done_once", 64'(frame_done), 64'(0));
    end
    repeat (2) step();

    // Asynchronous reset mid-cycle with two lanes pending
    w0 = n_wr;
    put(0, 100, 100, 24'hDEAD01);
    put(1, 101, 100, 24'hDEAD02);
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'(0));
    chk("arst_addr", 64'(wr_addr), 64'(0));
    chk("arst_data", 64'(wr_data), 64'(0));
    chk("arst_ready", 64'(lane_ready), 64'(3'b111));
    chk("arst_pixels", 64'(pixels_written), 64'(0));
    chk("arst_overflow", 64'(overflow), 64'(0));
    chk("arst_range_err", 64'(range_err), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) step();
    chk("arst_no_writes", 64'(n_wr), 64'(w0));
    chk("arst_ready_idle", 64'(lane_ready), 64'(3'b111));

    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    chk("final_fd_count", 64'(n_fd), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
